// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  function automatic logic rr_pick(input logic i_if, input logic i_dm, input logic i_last);
    if (i_if && i_dm) return ~i_last;
    return i_dm ? SEL_DM : SEL_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating ISSUE-cycle counter with an expired flag at MAX_WAIT.
module mem_port_arbiter_wait_timer #(
  parameter int MAX_WAIT = 15,
  localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max  = (r_cnt == CNT_W'(MAX_WAIT));
  assign o_expired = w_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_en && !w_at_max) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF/DM) arbiter and sequencer for the shared memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_sel,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  arb_state_e        r_state, w_next;
  logic              r_sel, r_last, r_we, r_abort;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata, w_cap;
  logic              w_any_req, w_pick, w_expired, w_finish;

  assign w_any_req = if_req | dm_req;
  assign w_pick    = rr_pick(if_req, dm_req, r_last);
  assign w_finish  = mem_ack | w_expired;
  // Writes and aborts return zero; only an acked read carries memory data.
  assign w_cap     = (r_we || !mem_ack) ? '0 : mem_rdata;

  mem_port_arbiter_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == IDLE),
    .i_en     ((r_state == ISSUE) && !mem_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ISSUE;
      ISSUE:   if (w_finish)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= SEL_IF;
      r_last     <= SEL_DM;
      r_we       <= 1'b0;
      r_abort    <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any_req) begin
          r_sel   <= w_pick;
          r_last  <= w_pick;
          r_we    <= dm_we & (w_pick == SEL_DM);
          r_abort <= 1'b0;
        end
        ISSUE: if (w_finish) begin
          r_abort <= ~mem_ack;
          if (r_sel == SEL_DM) r_dm_rdata <= w_cap;
          else                 r_if_rdata <= w_cap;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_done     = 1'b0;
    dm_done     = 1'b0;
    err_timeout = 1'b0;
    case (r_state)
      ISSUE: begin
        mem_req = 1'b1;
        mem_we  = r_we;
        if_gnt  = (r_sel == SEL_IF);
        dm_gnt  = (r_sel == SEL_DM);
      end
      DONE: begin
        if_gnt      = (r_sel == SEL_IF);
        dm_gnt      = (r_sel == SEL_DM);
        if_done     = (r_sel == SEL_IF);
        dm_done     = (r_sel == SEL_DM);
        err_timeout = r_abort;
      end
      default: ;
    endcase
  end

  assign mem_sel  = r_sel;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule
